// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop input synchronizer feeding a show-ahead byte FIFO.
// Frame errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV = 417,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    frame_err,
  output logic                    overrun
);

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, rxs_prev_q;
  logic [2:0]      vld_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_c, ferr_c, fall_c, tick_c, rxs;

  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, frame_err_q, overrun_q;
  logic            pop_c, full_c, wr_en_c, overrun_d;

  // vld_q masks the reset value of the synchronizer so a line already low at reset never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      vld_q      <= '0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      rxs_prev_q <= sync2_q;
      vld_q      <= {vld_q[1:0], 1'b1};
    end
  end

  assign rxs    = sync2_q;
  assign fall_c = vld_q[2] & rxs_prev_q & ~rxs;
  assign tick_c = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_c    = 1'b0;
    ferr_c    = 1'b0;
    if (state_q != IDLE) begin
      timer_d = tick_c ? TW'(CLK_DIV - 1) : timer_q - TW'(1);
    end
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          timer_d = TW'(CLK_DIV / 2 - 1);
        end
      end
      START: begin
        if (tick_c) begin
          if (!rxs) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          shift_d = {rxs, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (tick_c) begin
          state_d = IDLE;
          if (rxs) push_c = 1'b1;
          else     ferr_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // When full, a simultaneous pop frees the head slot that the write pointer also addresses
  assign pop_c     = out_valid_q & out_ready;
  assign full_c    = (count_q == CW'(DEPTH));
  assign wr_en_c   = push_c & (~full_c | pop_c);
  assign overrun_d = push_c & full_c & ~pop_c;
  assign count_d   = count_q + CW'(wr_en_c) - CW'(pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      frame_err_q <= ferr_c;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = out_valid_q;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001: Parameter CLK_DIV, default 417, is the number of clk cycles per UART bit (48 MHz / 115200); the legal minimum is 8.
REQ-002: Parameter DEPTH, default 8, is the FIFO depth in bytes; it SHALL be a power of two, 2..64.
REQ-003: clk  input  1  48 MHz user clock, the same clock as usb2uart clk48.
REQ-004: rst_n  input  1  reset, asynchronous and active-low; all state is cleared while it is low.
REQ-005: rx  input  1  asynchronous serial line carrying usb2uart uart_tx; idle level is high.
REQ-006: out_data  output  8  byte at the FIFO head.
REQ-007: out_valid  output  1  FIFO is non-empty and out_data is valid.
REQ-008: out_ready  input  1  consumer accepts out_data.
REQ-009: fifo_count  output  $clog2(DEPTH)+1  number of bytes currently stored.
REQ-010: frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011: overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012: rx SHALL pass through a two-flop synchronizer, reset to 1, before any use; all following timing is relative to the synchronized signal rxs.
REQ-013: The receive FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-014: IDLE -> START on a falling edge of rxs (previous rxs 1, current rxs 0); the bit-timer loads CLK_DIV/2 - 1.
REQ-015: The bit-timer SHALL decrement each cycle; a "sample tick" occurs when it is 0, and on that tick it reloads CLK_DIV - 1.
REQ-016: START, sample tick:
- rxs = 0 -> DATA, bit index 0.
- rxs = 1 -> IDLE (false start); no pulse and no push.
REQ-017: DATA, each sample tick: shift rxs into the shift register LSB-first.
- After bit index 7 -> STOP; otherwise increment the bit index.
REQ-018: STOP, sample tick: return to IDLE in every case.
- rxs = 1 -> push the byte into the FIFO.
- rxs = 0 -> frame_err pulses high for exactly that cycle and the byte is discarded.
REQ-019: After a framing error, a new start SHALL require rxs to return high first; a held-low break line SHALL produce exactly one frame_err.
REQ-020: FIFO behaviour:
- Push writes at the write pointer; pop occurs when out_valid && out_ready.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- fifo_count = pushes minus pops.
REQ-021: The FIFO SHALL be show-ahead: out_data equals the head entry whenever out_valid = 1.
- out_valid rises on the cycle after a push into an empty FIFO.
REQ-022: Push while full with no pop in the same cycle: the byte is dropped, overrun pulses for one cycle, and FIFO contents are unchanged.
REQ-023: Push and pop in the same cycle while full: both are performed, overrun stays 0, and fifo_count stays DEPTH.
REQ-024: Push and pop in the same cycle while non-empty and not full: fifo_count is unchanged.
REQ-025: A pop while empty SHALL have no effect: out_valid stays 0 and fifo_count stays 0.
REQ-026: out_data is undefined while out_valid = 0; pops never alter entries that have not yet been read.
REQ-027: The receiver SHALL keep operating regardless of out_ready; the FIFO is the only buffering.
REQ-028: End-to-end latency: the stop-bit sample tick occurs CLK_DIV/2 + 9*CLK_DIV cycles (integer division) after the synchronized falling edge, plus 2 synchronizer cycles; out_valid follows 1 cycle later.

Reset
REQ-029: While rst_n = 0:
- FSM = IDLE, synchronizer flops = 1, bit-timer, bit index and shift register = 0.
- Pointers = 0, fifo_count = 0, out_valid = 0, frame_err = 0, overrun = 0, out_data = 8'h00.
REQ-030: When rst_n is asserted mid-frame, the partial byte SHALL be discarded with no pulse, and any stored FIFO bytes are lost.
REQ-031: After rst_n deasserts, a line that is already low SHALL NOT start a frame until a falling edge is seen.

Verification (CLK_DIV = 16, DEPTH = 4)
REQ-032: Send byte 8'hA5 with a good stop bit and out_ready = 0 -> fifo_count = 1, out_valid = 1, out_data = 8'hA5 one cycle after the stop sample; frame_err = 0.
REQ-033: Send 8'h3C with the stop bit driven low -> frame_err pulses once, fifo_count stays 0; a following 8'h5A frame is received correctly.
REQ-034: Drive a 4-cycle low glitch on an idle line -> FSM returns to IDLE from START, with no push and no pulses.
REQ-035: With out_ready = 0, send 8'h01..8'h05 -> fifo_count = 4 and one overrun pulse; then assert out_ready -> bytes 01, 02, 03, 04 are delivered in order and out_valid = 0 afterwards.
REQ-036: Fill the FIFO to 4, then hold out_ready = 1 so a pop coincides with the 5th stop-sample push -> no overrun and fifo_count stays 4.
REQ-037: Assert rst_n low during bit 4 of a frame, release it with rx high, then send 8'hC3 -> exactly one byte 8'hC3 is received with no frame_err.
